spi_rx_buffer: RTL and testbench
================================

SPI_RX_BUFFER -- requirements
Module: spi_rx_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of FIFO entries (power of two, 2..16).
REQ-002 Parameter DW, default 16, maximum transfer width in bits.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 xfer_done  input  1  level; high while the SPI engine holds a completed transfer.
REQ-006 xfer_data  input  DW  received word; valid whenever xfer_done=1.
REQ-007 xfer_len  input  1  transfer length; 0 = 8 bits, 1 = 16 bits.
REQ-008 received  output  1  acknowledge to the SPI engine; this is the engine's received input.
REQ-009 rd_en  input  1  pop request from the consumer.
REQ-010 rd_data  output  DW  head-of-FIFO word, first-word-fall-through.
REQ-011 rd_len  output  1  xfer_len stored with the head entry.
REQ-012 empty  output  1  high when count=0.
REQ-013 full  output  1  high when count=DEPTH.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 overflow  output  1  sticky flag: a completed transfer was dropped.
REQ-016 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-017 The block SHALL implement a 3-state handshake FSM: IDLE, CAPTURE, ACK.
REQ-018 IDLE -> CAPTURE on the first clk edge with xfer_done=1; otherwise remain in IDLE.
REQ-019 CAPTURE lasts exactly 1 cycle: write {xfer_data, xfer_len} if a write slot is available, else set overflow and drop the word; then go to ACK.
REQ-020 In ACK, received SHALL be 1; ACK -> IDLE on the first edge with xfer_done=0 (4-phase handshake); received=0 in IDLE and CAPTURE.
REQ-021 Each xfer_done assertion SHALL produce exactly one write attempt, however long it stays high.
REQ-022 When xfer_len=0, bits DW-1:8 of the stored word SHALL be forced to 0.
REQ-023 rd_data/rd_len SHALL reflect the head entry combinationally; with empty=1, rd_data SHALL read 0.
REQ-024 rd_en with empty=0 SHALL pop one entry on that edge; rd_en with empty=1 SHALL be ignored, with no state change.
REQ-025 Write slot available = (full=0) OR (rd_en=1 AND empty=0) in the same cycle; a simultaneous write and pop leaves count unchanged.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-027 Latency: a word written in CAPTURE cycle N SHALL be visible on rd_data in cycle N+1 if the FIFO was empty.
REQ-028 overflow SHALL remain 1 until clr_ovf=1; if clr_ovf and a new drop coincide, overflow SHALL be 1.
REQ-029 full, empty and count SHALL be registered-consistent, all derived from the same pointer state.

Reset
REQ-030 With rst=1: FSM=IDLE, pointers=0, count=0, empty=1, full=0, received=0, overflow=0, rd_data=0, rd_len=0.
REQ-031 rst asserted mid-handshake SHALL abort the handshake without a write; after release, a still-high xfer_done SHALL be treated as a new transfer.
REQ-032 Memory contents need not be cleared; only pointer and flag state is defined.

Verification
REQ-033 Single 8-bit transfer: xfer_data=16'hABCD, xfer_len=0, xfer_done held 5 cycles -> one write; rd_data=16'h00CD; rd_len=0; received high from the cycle after CAPTURE until xfer_done drops.
REQ-034 Fill test: 9 transfers with DEPTH=8 and no reads -> full=1 after the 8th; 9th dropped, overflow=1, count=8, received still completes the handshake.
REQ-035 Full plus pop: FIFO full, rd_en=1 in the CAPTURE cycle of a new 16-bit transfer 16'h1234 -> count stays 8, overflow=0, 16'h1234 becomes the last entry.
REQ-036 Wrap-around: 20 alternating write/pop pairs -> data order preserved, count toggles 0/1, pointers wrap with no loss.
REQ-037 Pop on empty: rd_en=1 with empty=1 -> count stays 0, no flag change.
REQ-038 Reset in ACK: assert rst while received=1 -> received=0 immediately; with xfer_done still high after release, exactly one new write occurs.

Source files
------------

// File: rtl/spi_rx_buffer.sv
// Receive-side buffer for an SPI engine: 4-phase handshake capture into a
// first-word-fall-through FIFO with sticky overflow on dropped transfers.
module spi_rx_buffer #(
    parameter int DEPTH = 8,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     xfer_done,
    input  logic [DW-1:0]            xfer_data,
    input  logic                     xfer_len,
    output logic                     received,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     rd_len,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        ACK
    } state_t;

    state_t          state_q;
    logic            received_q;
    logic            overflow_q;
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;
    logic [DW:0]     mem_q [DEPTH];

    logic [AW:0]     count_d;
    logic            empty_d;
    logic            full_d;
    logic            pop;
    logic            slot;
    logic            wr_en;
    logic [DW-1:0]   wdata;
    logic [DW:0]     head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // from the same registered state without a separate counter.
    always_comb begin
        count_d = wr_ptr_q - rd_ptr_q;
        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_CNT);
        pop     = rd_en && !empty_d;
        slot    = !full_d || pop;
        wr_en   = (state_q == CAPTURE) && slot;
    end

    always_comb begin
        wdata = xfer_data;
        if (!xfer_len) begin
            for (int unsigned i = 8; i < DW; i++) begin
                wdata[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            received_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    received_q <= 1'b0;
                    if (xfer_done) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_q    <= ACK;
                    received_q <= 1'b1;
                end
                ACK: begin
                    if (!xfer_done) begin
                        state_q    <= IDLE;
                        received_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    received_q <= 1'b0;
                end
            endcase

            // A drop in the same cycle as a clear wins so no loss goes unseen.
            if ((state_q == CAPTURE) && !slot) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {xfer_len, wdata};
        end
    end

    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_data  = empty_d ? '0 : head[DW-1:0];
    assign rd_len   = empty_d ? 1'b0 : head[DW];
    assign empty    = empty_d;
    assign full     = full_d;
    assign count    = count_d;
    assign overflow = overflow_q;
    assign received = received_q;

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Directed and randomized checks of spi_rx_buffer against a queue-based model
// of the buffer's transfer/pop rules.
module tb_spi_rx_buffer;

    localparam int DEPTH = 8;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          xfer_done;
    logic [DW-1:0] xfer_data;
    logic          xfer_len;
    logic          received;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_len;
    logic          empty;
    logic          full;
    logic [3:0]    count;
    logic          overflow;
    logic          clr_ovf;

    int n_cmp = 0;
    int n_err = 0;

    // Model: each entry is {len, data}; overflow is a plain sticky bit.
    logic [DW:0] mq [$];
    logic        m_ovf;

    spi_rx_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .xfer_done(xfer_done), .xfer_data(xfer_data),
        .xfer_len(xfer_len), .received(received), .rd_en(rd_en),
        .rd_data(rd_data), .rd_len(rd_len), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag);
        logic [DW:0] h;
        h = (mq.size() == 0) ? '0 : mq[0];
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(h[DW-1:0]));
        chk({tag, ".rd_len"}, 32'(rd_len), 32'(h[DW]));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Model of the capture edge: optional pop first, then push or drop.
    task automatic model_capture(input logic [DW-1:0] d, input logic l,
                                 input logic pop, input logic clr);
        logic [DW-1:0] sd;
        sd = l ? d : (d & 16'h00FF);
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (mq.size() < DEPTH) begin
            mq.push_back({l, sd});
            if (clr) m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic xfer(input string tag, input logic [DW-1:0] d, input logic l,
                        input int hold, input logic pop, input logic clr);
        xfer_done = 1'b1;
        xfer_data = d;
        xfer_len  = l;
        step();
        chk({tag, ".rcv_cap"}, 32'(received), 32'd0);
        rd_en   = pop;
        clr_ovf = clr;
        step();
        model_capture(d, l, pop, clr);
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        xfer_data = ~d;
        chk({tag, ".rcv_ack"}, 32'(received), 32'd1);
        chk_state(tag);
        for (int i = 2; i < hold; i++) begin
            step();
            chk({tag, ".rcv_hold"}, 32'(received), 32'd1);
            chk({tag, ".cnt_hold"}, 32'(count), 32'(mq.size()));
        end
        xfer_done = 1'b0;
        step();
        chk({tag, ".rcv_rel"}, 32'(received), 32'd0);
    endtask

    task automatic pop1(input string tag);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        chk_state(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; xfer_done = 1'b0; xfer_data = '0; xfer_len = 1'b0;
        rd_en = 1'b0; clr_ovf = 1'b0;
        do_reset();
        chk("reset.rcv", 32'(received), 32'd0);
        chk_state("reset");

        // Single 8-bit transfer held for 5 cycles
        xfer("single", 16'hABCD, 1'b0, 5, 1'b0, 1'b0);
        chk_state("single_post");
        chk("single.rd_data", 32'(rd_data), 32'h00CD);
        pop1("single_pop");

        // Fill: 9 transfers, 9th dropped
        for (int i = 0; i < 9; i++) begin
            xfer("fill", 16'(16'h1100 + i), 1'(i & 1), 2 + (i % 3), 1'b0, 1'b0);
        end
        chk_state("fill_end");
        chk("fill.ovf", 32'(overflow), 32'd1);

        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        m_ovf = 1'b0;
        chk_state("clr_ovf");

        // Full plus pop in the capture cycle
        xfer("fullpop", 16'h1234, 1'b1, 3, 1'b1, 1'b0);
        chk("fullpop.cnt", 32'(count), 32'd8);
        chk("fullpop.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop1("drain");
        chk("drain.last", 32'(empty), 32'd1);

        // Pop on empty
        pop1("pop_empty");

        // Wrap-around pairs
        for (int i = 0; i < 20; i++) begin
            xfer("wrap_w", 16'($urandom), 1'($urandom), 2, 1'b0, 1'b0);
            chk("wrap.cnt1", 32'(count), 32'd1);
            pop1("wrap_p");
        end

        // Reset during ACK with xfer_done still high
        xfer_done = 1'b1; xfer_data = 16'h5A5A; xfer_len = 1'b1;
        step();
        step();
        chk("rstack.rcv_before", 32'(received), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstack.rcv_async", 32'(received), 32'd0);
        mq.delete();
        m_ovf = 1'b0;
        chk_state("rstack.in_reset");
        step();
        rst = 1'b0;
        step();
        chk("rstack.cap", 32'(received), 32'd0);
        step();
        model_capture(16'h5A5A, 1'b1, 1'b0, 1'b0);
        chk_state("rstack.write");
        step();
        step();
        chk_state("rstack.hold");
        xfer_done = 1'b0;
        step();
        chk("rstack.rel", 32'(received), 32'd0);

        // Randomized mix
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0, 1: xfer("rnd_x", 16'($urandom), 1'($urandom), int'($urandom_range(2, 4)),
                           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
                2: pop1("rnd_p");
                default: begin
                    clr_ovf = 1'($urandom);
                    step();
                    if (clr_ovf) m_ovf = 1'b0;
                    clr_ovf = 1'b0;
                    chk_state("rnd_idle");
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
